alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - LA32R ALU decode/issue stage with main+skid two-entry buffer
// Optional macro INE_TRAP_EN: issue unrecognised instructions with out_ine instead of dropping them.
module alu_issue (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_alu_op,
    output logic [31:0] out_src1,
    output logic [31:0] out_src2,
    output logic [4:0]  out_dest,
    output logic        out_gr_we
`ifdef INE_TRAP_EN
    ,
    output logic        out_ine
`endif
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    typedef struct packed {
        logic [11:0] alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  dest;
        logic        gr_we;
`ifdef INE_TRAP_EN
        logic        ine;
`endif
    } bundle_t;

    state_t      r_state, w_next;
    bundle_t     r_main, r_skid, w_bundle;
    logic        r_in_ready;
    logic        w_recog, w_push, w_consume;
    logic        w_load_main, w_load_skid, w_main_from_skid;
    logic [11:0] w_op;
    logic [19:0] w_si20;

    assign rf_raddr1 = in_inst[9:5];
    assign rf_raddr2 = in_inst[14:10];
    assign w_si20    = in_inst[24:5];

    always_comb begin
        w_op = '0;
        case (in_inst[31:15])
            17'h00020: w_op[0]  = 1'b1;
            17'h00022: w_op[1]  = 1'b1;
            17'h00024: w_op[2]  = 1'b1;
            17'h00025: w_op[3]  = 1'b1;
            17'h00029: w_op[4]  = 1'b1;
            17'h00028: w_op[5]  = 1'b1;
            17'h0002A: w_op[6]  = 1'b1;
            17'h0002B: w_op[7]  = 1'b1;
            17'h00081: w_op[8]  = 1'b1;
            17'h00089: w_op[9]  = 1'b1;
            17'h00091: w_op[10] = 1'b1;
            default: begin
                if (in_inst[31:22] == 10'h00A) w_op[0]  = 1'b1;
                if (in_inst[31:25] == 7'h0A)   w_op[11] = 1'b1;
            end
        endcase
    end

    assign w_recog = |w_op;

    // lu12i.w passes si20 rotated so the ALU's lui path restores si20<<12.
    always_comb begin
        w_bundle        = '0;
        w_bundle.alu_op = w_op;
        w_bundle.dest   = in_inst[4:0];
        w_bundle.gr_we  = w_recog && (in_inst[4:0] != 5'd0);
        w_bundle.src1   = w_op[11] ? 32'd0 : rf_rdata1;
        if (w_op[8] || w_op[9] || w_op[10])
            w_bundle.src2 = {27'd0, in_inst[14:10]};
        else if (in_inst[31:22] == 10'h00A)
            w_bundle.src2 = {{20{in_inst[21]}}, in_inst[21:10]};
        else if (w_op[11])
            w_bundle.src2 = {12'd0, w_si20[4:0], w_si20[19:5]};
        else
            w_bundle.src2 = rf_rdata2;
`ifdef INE_TRAP_EN
        w_bundle.ine    = !w_recog;
`endif
    end

`ifdef INE_TRAP_EN
    assign w_push = in_valid && r_in_ready;
`else
    assign w_push = in_valid && r_in_ready && w_recog;
`endif
    assign w_consume = (r_state != S_EMPTY) && out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_EMPTY;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            S_EMPTY: if (w_push) begin
                w_next      = S_ONE;
                w_load_main = 1'b1;
            end
            S_ONE: begin
                if (w_push && !w_consume) begin
                    w_next      = S_FULL;
                    w_load_skid = 1'b1;
                end else if (w_push && w_consume) begin
                    w_load_main = 1'b1;
                end else if (w_consume) begin
                    w_next = S_EMPTY;
                end
            end
            S_FULL: if (w_consume) begin
                w_next           = S_ONE;
                w_main_from_skid = 1'b1;
            end
            default: w_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_load_main)           r_main <= w_bundle;
            else if (w_main_from_skid) r_main <= r_skid;
            if (w_load_skid)           r_skid <= w_bundle;
            r_in_ready <= (w_next != S_FULL);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state != S_EMPTY);
    assign out_alu_op = r_main.alu_op;
    assign out_src1   = r_main.src1;
    assign out_src2   = r_main.src2;
    assign out_dest   = r_main.dest;
    assign out_gr_we  = r_main.gr_we;
`ifdef INE_TRAP_EN
    assign out_ine    = r_main.ine;
`endif

endmodule
